// File: rtl/sample_debounce_cmp_pkg.sv
// Shared encodings for compare-based monitor cells: condition modes and
// debounce FSM states.
package sample_debounce_cmp_pkg;

  typedef enum logic [1:0] {
    MODE_UGT = 2'b00,
    MODE_ULT = 2'b01,
    MODE_SGT = 2'b10,
    MODE_SLT = 2'b11
  } cmp_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_FIRED = 2'b10
  } dbc_state_t;

endpackage

// File: rtl/sample_debounce_cmp_cond_decode.sv
// Decodes A>B / A<B (signed or unsigned) from the flags of an A-B subtract
// with carry-in 0, where carry=1 means no borrow.
module cmp_cond_decode
  import sample_debounce_cmp_pkg::*;
(
  input  logic       carry,
  input  logic       zero,
  input  logic       sign,
  input  logic       overflow,
  input  logic [1:0] mode,
  output logic       match
);

  always_comb begin
    match = 1'b0;
    case (cmp_mode_t'(mode))
      MODE_UGT: match = carry & ~zero;
      MODE_ULT: match = ~carry;
      MODE_SGT: match = ~zero & (sign == overflow);
      MODE_SLT: match = sign != overflow;
      default:  match = 1'b0;
    endcase
  end

endmodule

// File: rtl/sample_debounce_cmp.sv
// Debounced compare monitor: fires a level interrupt after a run of
// consecutive matching samples from an upstream add/sub/compare cell.
//
// state    | meaning
// ST_IDLE  | disabled or just out of reset, samples ignored
// ST_ARMED | counting consecutive matching samples
// ST_FIRED | threshold reached, irq held until ack
module sample_debounce_cmp
  import sample_debounce_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             valid,
  input  logic [WIDTH-1:0] d,
  input  logic             carry,
  input  logic             zero,
  input  logic             sign,
  input  logic             overflow,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] threshold,
  input  logic             ack,
  output logic             match,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] value,
  output logic             irq
);

  dbc_state_t       state, state_nxt;
  logic             match_nxt, irq_nxt, cond;
  logic [WIDTH-1:0] count_nxt, value_nxt, thr_eff, cnt_inc;

  cmp_cond_decode u_decode (
    .carry    (carry),
    .zero     (zero),
    .sign     (sign),
    .overflow (overflow),
    .mode     (mode),
    .match    (cond)
  );

  // Threshold 0 behaves as 1; the count saturates rather than wrapping.
  assign thr_eff = (threshold == '0) ? WIDTH'(1) : threshold;
  assign cnt_inc = (&count) ? count : count + WIDTH'(1);

  always_comb begin
    state_nxt = state;
    match_nxt = match;
    count_nxt = count;
    value_nxt = value;
    irq_nxt   = irq;
    if (!enable) begin
      state_nxt = ST_IDLE;
      match_nxt = 1'b0;
      count_nxt = '0;
      irq_nxt   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (valid) begin
            match_nxt = cond;
            if (cond) begin
              count_nxt = cnt_inc;
              if (cnt_inc >= thr_eff) begin
                value_nxt = d;
                irq_nxt   = 1'b1;
                state_nxt = ST_FIRED;
              end
            end else begin
              count_nxt = '0;
            end
          end
        end
        ST_FIRED: begin
          if (valid) match_nxt = cond;
          // A sample arriving with ack opens the new run but cannot fire it.
          if (ack) begin
            irq_nxt   = 1'b0;
            state_nxt = ST_ARMED;
            count_nxt = (valid && cond) ? WIDTH'(1) : '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      match <= 1'b0;
      count <= '0;
      value <= '0;
      irq   <= 1'b0;
    end else begin
      state <= state_nxt;
      match <= match_nxt;
      count <= count_nxt;
      value <= value_nxt;
      irq   <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_sample_debounce_cmp.sv
// Directed self-checking bench for sample_debounce_cmp.
module tb_sample_debounce_cmp;

  logic        clk, rst_n, enable, valid, carry, zero, sign, overflow, ack;
  logic [1:0]  mode;
  logic [15:0] d, threshold;
  logic        match, irq;
  logic [15:0] count, value;
  int          n_checks = 0;
  int          n_fail = 0;

  sample_debounce_cmp #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .valid(valid), .d(d),
    .carry(carry), .zero(zero), .sign(sign), .overflow(overflow),
    .mode(mode), .threshold(threshold), .ack(ack),
    .match(match), .count(count), .value(value), .irq(irq)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic c, input logic z, input logic s,
                        input logic o, input logic [15:0] dv);
    valid = 1; carry = c; zero = z; sign = s; overflow = o; d = dv;
    step();
    valid = 0;
  endtask

  task automatic rearm();
    enable = 0;
    step();
    enable = 1;
    step();
  endtask

  task automatic test_reset();
    step();
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %0d expected 0", match); end
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (value !== 16'd0) begin n_fail++; $display("FAIL reset_value: got %h expected 0000", value); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0d expected 0", irq); end
    rst_n = 1;
    enable = 1;
    step();
  endtask

  task automatic test_mode00_fire();
    mode = 2'b00; threshold = 16'd3;
    sample(1, 0, 0, 0, 16'h0011);
    n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL m00_count1: got %0d expected 1", count); end
    n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL m00_match1: got %0d expected 1", match); end
    sample(1, 0, 0, 0, 16'h0022);
    n_checks++; if (count !== 16'd2) begin n_fail++; $display("FAIL m00_count2: got %0d expected 2", count); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL m00_irq2: got %0d expected 0", irq); end
    sample(1, 0, 0, 0, 16'h0033);
    n_checks++; if (count !== 16'd3) begin n_fail++; $display("FAIL m00_count3: got %0d expected 3", count); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL m00_irq3: got %0d expected 1", irq); end
    n_checks++; if (value !== 16'h0033) begin n_fail++; $display("FAIL m00_value: got %h expected 0033", value); end
    sample(1, 0, 0, 0, 16'h0044);
    n_checks++; if (count !== 16'd3) begin n_fail++; $display("FAIL fired_count_hold: got %0d expected 3", count); end
    n_checks++; if (value !== 16'h0033) begin n_fail++; $display("FAIL fired_value_hold: got %h expected 0033", value); end
    sample(0, 0, 0, 0, 16'h0055);
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL fired_match_upd: got %0d expected 0", match); end
    ack = 1;
    step();
    ack = 0;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ack_irq: got %0d expected 0", irq); end
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL ack_count: got %0d expected 0", count); end
  endtask

  task automatic test_mode10_break();
    rearm();
    mode = 2'b10; threshold = 16'd3;
    sample(0, 0, 0, 0, 16'h0001);
    n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL m10_count1: got %0d expected 1", count); end
    sample(0, 0, 1, 1, 16'h0002);
    n_checks++; if (count !== 16'd2) begin n_fail++; $display("FAIL m10_count2: got %0d expected 2", count); end
    sample(0, 0, 1, 0, 16'h0003);
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL m10_count0: got %0d expected 0", count); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL m10_match0: got %0d expected 0", match); end
    sample(0, 0, 0, 0, 16'h0004);
    n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL m10_count1b: got %0d expected 1", count); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL m10_irq: got %0d expected 0", irq); end
    // No valid, and ack while armed: neither changes anything.
    step();
    n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL idle_cycle_count: got %0d expected 1", count); end
    ack = 1;
    step();
    ack = 0;
    n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL ack_armed_count: got %0d expected 1", count); end
    enable = 0;
    step();
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL disable_count: got %0d expected 0", count); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL disable_match: got %0d expected 0", match); end
    n_checks++; if (value !== 16'h0033) begin n_fail++; $display("FAIL disable_value: got %h expected 0033", value); end
    enable = 1;
    step();
  endtask

  task automatic test_ack_same_cycle();
    mode = 2'b01; threshold = 16'd1;
    sample(0, 0, 0, 0, 16'h00A1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ackv_fire: got %0d expected 1", irq); end
    ack = 1;
    sample(0, 0, 0, 0, 16'h00A2);
    ack = 0;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ackv_irq: got %0d expected 0", irq); end
    n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL ackv_count: got %0d expected 1", count); end
    sample(0, 0, 0, 0, 16'h00A3);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ackv_armed: got %0d expected 1", irq); end
    n_checks++; if (value !== 16'h00A3) begin n_fail++; $display("FAIL ackv_value: got %h expected 00a3", value); end
  endtask

  task automatic test_threshold_zero();
    rearm();
    mode = 2'b00; threshold = 16'd0;
    sample(1, 0, 0, 0, 16'h0BEE);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL thr0_irq: got %0d expected 1", irq); end
    n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL thr0_count: got %0d expected 1", count); end
  endtask

  task automatic test_threshold_change();
    rearm();
    mode = 2'b00; threshold = 16'd5;
    for (int i = 0; i < 3; i++) sample(1, 0, 0, 0, 16'h0100 + 16'(i));
    n_checks++; if (count !== 16'd3) begin n_fail++; $display("FAIL thrchg_count3: got %0d expected 3", count); end
    threshold = 16'd2;
    sample(1, 0, 0, 0, 16'h0C0D);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL thrchg_irq: got %0d expected 1", irq); end
    n_checks++; if (count !== 16'd4) begin n_fail++; $display("FAIL thrchg_count: got %0d expected 4", count); end
    n_checks++; if (value !== 16'h0C0D) begin n_fail++; $display("FAIL thrchg_value: got %h expected 0c0d", value); end
  endtask

  task automatic test_saturation();
    int   fires;
    logic irq_prev;
    rearm();
    mode = 2'b00; threshold = 16'hFFFF;
    valid = 1; carry = 1; zero = 0; d = 16'h5A5A;
    fires = 0;
    irq_prev = irq;
    for (int i = 0; i < 70000; i++) begin
      step();
      if (irq && !irq_prev) fires++;
      irq_prev = irq;
    end
    valid = 0;
    n_checks++; if (count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count: got %h expected ffff", count); end
    n_checks++; if (fires !== 1) begin n_fail++; $display("FAIL sat_fires: got %0d expected 1", fires); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL sat_irq: got %0d expected 1", irq); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 0;
    #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_irq: got %0d expected 0", irq); end
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", count); end
    n_checks++; if (value !== 16'd0) begin n_fail++; $display("FAIL arst_value: got %h expected 0000", value); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL arst_match: got %0d expected 0", match); end
    enable = 0; threshold = 16'd1; mode = 2'b00;
    valid = 1; carry = 1; zero = 0; d = 16'h7777;
    #1;
    rst_n = 1;
    step();
    step();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_disabled_irq: got %0d expected 0", irq); end
    enable = 1;
    step();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_arming_irq: got %0d expected 0", irq); end
    step();
    valid = 0;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL arst_refire_irq: got %0d expected 1", irq); end
    n_checks++; if (value !== 16'h7777) begin n_fail++; $display("FAIL arst_refire_value: got %h expected 7777", value); end
  endtask

  initial begin
    rst_n = 0; enable = 0; valid = 0; d = '0; carry = 0; zero = 0;
    sign = 0; overflow = 0; mode = 2'b00; threshold = '0; ack = 0;
    test_reset();
    test_mode00_fire();
    test_mode10_break();
    test_ack_same_cycle();
    test_threshold_zero();
    test_threshold_change();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
